mem_port_arbiter: RTL and testbench

- Shares one magic_memory port between the datapath's instruction-fetch side (I) and its data side (D).
- Latches the winning request, drives the memory, and routes the response and read data back to the granted requester.
- Replaces the two-memory arrangement with a single memory plus this arbiter.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one magic_memory port between instruction fetch (I) and data (D) requesters.
// Optional ARB_ROUND_ROBIN_EN: alternate the grant on simultaneous I+D requests (default: D wins).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic [1:0]              state_dbg
);

  // Handshake: a requester raises read/write and holds it (with address/data) until its
  // one-cycle x_resp pulse, then drops it in the following cycle. The memory sees a strobe
  // held from the cycle after the grant edge until mem_resp=1; x_rdata is valid with x_resp.

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  d_req;
  logic                  grant_d, grant_i;
  logic                  mem_read_q, mem_write_q;
  logic [MW-1:0]         mem_wmask_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;
`endif

  always_comb begin
    d_req     = d_read | d_write;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_read) begin
          grant_d = !last_grant_d;
          grant_i = last_grant_d;
        end else begin
          grant_d = d_req;
          grant_i = i_read;
        end
`else
        grant_d = d_req;
        grant_i = i_read && !d_req;
`endif
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: if (mem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The memory side is driven only from registers captured at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wmask_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        mem_read_q    <= !d_write;
        mem_write_q   <= d_write;
        mem_wmask_q   <= d_write ? d_wmask : '0;
        mem_address_q <= d_address;
        mem_wdata_q   <= d_write ? d_wdata : '0;
      end else if (grant_i) begin
        mem_read_q    <= 1'b1;
        mem_write_q   <= 1'b0;
        mem_wmask_q   <= '0;
        mem_address_q <= i_address;
        mem_wdata_q   <= '0;
      end else if (state != IDLE && mem_resp) begin
        mem_read_q    <= 1'b0;
        mem_write_q   <= 1'b0;
        mem_wmask_q   <= '0;
        mem_address_q <= '0;
        mem_wdata_q   <= '0;
      end
      if (i_resp) i_rdata_q <= mem_rdata;
      if (d_resp) d_rdata_q <= mem_rdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)          last_grant_d <= 1'b0;
    else if (grant_d) last_grant_d <= 1'b1;
    else if (grant_i) last_grant_d <= 1'b0;
  end
`endif

  assign i_resp      = (state == SERVE_I) && mem_resp;
  assign d_resp      = (state == SERVE_D) && mem_resp;
  assign i_rdata     = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata     = d_resp ? mem_rdata : d_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset/idle, I fetch, D write, contention, stability, reset mid-op.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [1:0]  d_wmask = '0;
  logic [15:0] d_address = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_I = 2'd1, S_D = 2'd2;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mem_resp  = (c == 4);
      mem_rdata = 16'hDEAD;
      #1;
      checks++;
      if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !== 36'd0) begin
        errors++;
        $display("FAIL reset_mem_idle cycle %0d got rd=%0b wr=%0b mask=%b addr=%h wdata=%h want all 0",
                 c, mem_read, mem_write, mem_wmask, mem_address, mem_wdata);
      end
      checks++;
      if ({i_resp, d_resp, state_dbg} !== 4'd0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
        errors++;
        $display("FAIL reset_resp_idle cycle %0d got iresp=%0b dresp=%0b state=%0d irdata=%h drdata=%h want 0",
                 c, i_resp, d_resp, state_dbg, i_rdata, d_rdata);
      end
      step();
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_i_fetch();
    i_read = 1'b1;
    i_address = 16'h0040;
    step();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h0040 || state_dbg !== S_I) begin
        errors++;
        $display("FAIL ifetch_strobe cycle %0d got rd=%0b wr=%0b addr=%h state=%0d want 1 0 0040 1",
                 c, mem_read, mem_write, mem_address, state_dbg);
      end
      checks++;
      if (i_resp !== 1'b0) begin
        errors++;
        $display("FAIL ifetch_early_resp got %0b want 0", i_resp);
      end
      step();
    end
    mem_resp = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== 16'h1234 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_resp got iresp=%0b irdata=%h dresp=%0b want 1 1234 0", i_resp, i_rdata, d_resp);
    end
    step();
    mem_resp = 1'b0;
    mem_rdata = 16'h5555;
    i_read = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== 16'h1234 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL ifetch_after got rd=%0b iresp=%0b irdata=%h state=%0d want 0 0 1234 0",
               mem_read, i_resp, i_rdata, state_dbg);
    end
    step();
  endtask

  task automatic test_d_write();
    d_write = 1'b1;
    d_address = 16'h0100;
    d_wdata = 16'hBEEF;
    d_wmask = 2'b01;
    step();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wmask !== 2'b01 || mem_wdata !== 16'hBEEF ||
        mem_address !== 16'h0100 || state_dbg !== S_D) begin
      errors++;
      $display("FAIL dwrite_strobe got wr=%0b rd=%0b mask=%b wdata=%h addr=%h state=%0d want 1 0 01 beef 0100 2",
               mem_write, mem_read, mem_wmask, mem_wdata, mem_address, state_dbg);
    end
    step();
    checks++;
    if (mem_write !== 1'b1 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL dwrite_hold got wr=%0b dresp=%0b want 1 0", mem_write, d_resp);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL dwrite_resp got dresp=%0b iresp=%0b want 1 0", d_resp, i_resp);
    end
    step();
    mem_resp = 1'b0;
    d_write = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_wmask !== 2'b00 || d_resp !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL dwrite_after got wr=%0b mask=%b dresp=%0b state=%0d want 0 00 0 0",
               mem_write, mem_wmask, d_resp, state_dbg);
    end
    step();
  endtask

  task automatic test_rw_both();
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 16'h0010;
    d_wdata = 16'h00A5;
    d_wmask = 2'b10;
    step();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wmask !== 2'b10 || mem_wdata !== 16'h00A5) begin
      errors++;
      $display("FAIL rw_both got wr=%0b rd=%0b mask=%b wdata=%h want 1 0 10 00a5",
               mem_write, mem_read, mem_wmask, mem_wdata);
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    step();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_read = 1'b1;
    i_address = 16'h0002;
    d_read = 1'b1;
    d_address = 16'h0200;
    d_wdata = 16'h1111;
    d_wmask = 2'b11;
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0200 || mem_wmask !== 2'b00 ||
        mem_wdata !== 16'h0000 || state_dbg !== S_D) begin
      errors++;
      $display("FAIL contend_d_first got rd=%0b addr=%h mask=%b wdata=%h state=%0d want 1 0200 00 0000 2",
               mem_read, mem_address, mem_wmask, mem_wdata, state_dbg);
    end
    d_address = 16'hFFFF;
    step();
    checks++;
    if (mem_address !== 16'h0200 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL addr_stable got addr=%h rd=%0b want 0200 1", mem_address, mem_read);
    end
    mem_resp = 1'b1;
    mem_rdata = 16'hABCD;
    #1;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== 16'hABCD || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL contend_d_resp got dresp=%0b drdata=%h iresp=%0b want 1 abcd 0", d_resp, d_rdata, i_resp);
    end
    step();
    mem_resp = 1'b0;
    d_read = 1'b0;
    #1;
    checks++;
    if (state_dbg !== S_IDLE || mem_read !== 1'b0 || d_rdata !== 16'hABCD) begin
      errors++;
      $display("FAIL contend_bubble got state=%0d rd=%0b drdata=%h want 0 0 abcd", state_dbg, mem_read, d_rdata);
    end
    step();
    checks++;
    if (state_dbg !== S_I || mem_read !== 1'b1 || mem_address !== 16'h0002) begin
      errors++;
      $display("FAIL contend_i_second got state=%0d rd=%0b addr=%h want 1 1 0002", state_dbg, mem_read, mem_address);
    end
    mem_resp = 1'b1;
    mem_rdata = 16'h7777;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== 16'h7777 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL contend_i_resp got iresp=%0b irdata=%h dresp=%0b want 1 7777 0", i_resp, i_rdata, d_resp);
    end
    step();
    mem_resp = 1'b0;
    i_read = 1'b0;
    step();
  endtask

  // A lone D read leaves D as the last grant, so round robin favours I next.
  task automatic test_second_contention();
    logic [1:0]  first_state;
    logic [15:0] first_addr, second_addr;
    d_read = 1'b1;
    d_address = 16'h0500;
    step();
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    d_read = 1'b0;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    first_state = S_I;
    first_addr = 16'h0004;
    second_addr = 16'h0600;
`else
    first_state = S_D;
    first_addr = 16'h0600;
    second_addr = 16'h0004;
`endif
    i_read = 1'b1;
    i_address = 16'h0004;
    d_read = 1'b1;
    d_address = 16'h0600;
    step();
    checks++;
    if (state_dbg !== first_state || mem_address !== first_addr) begin
      errors++;
      $display("FAIL contend2_first got state=%0d addr=%h want %0d %h", state_dbg, mem_address, first_state, first_addr);
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    if (first_state == S_I) i_read = 1'b0;
    else d_read = 1'b0;
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== second_addr) begin
      errors++;
      $display("FAIL contend2_second got rd=%0b addr=%h want 1 %h", mem_read, mem_address, second_addr);
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_op();
    i_read = 1'b1;
    i_address = 16'h0300;
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0300) begin
      errors++;
      $display("FAIL midrst_pre got rd=%0b addr=%h want 1 0300", mem_read, mem_address);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_read = 1'b0;
    checks++;
    if (mem_read !== 1'b0 || state_dbg !== S_IDLE || mem_address !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_clear got rd=%0b state=%0d addr=%h want 0 0 0000", mem_read, state_dbg, mem_address);
    end
    mem_resp = 1'b1;
    mem_rdata = 16'h9999;
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_late_resp got iresp=%0b dresp=%0b irdata=%h want 0 0 0000", i_resp, d_resp, i_rdata);
    end
    step();
    mem_resp = 1'b0;
    d_read = 1'b1;
    d_address = 16'h0440;
    checks++;
    if (state_dbg !== S_IDLE || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stay_idle got state=%0d rd=%0b want 0 0", state_dbg, mem_read);
    end
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0440 || state_dbg !== S_D) begin
      errors++;
      $display("FAIL midrst_fresh got rd=%0b addr=%h state=%0d want 1 0440 2", mem_read, mem_address, state_dbg);
    end
    mem_resp = 1'b1;
    mem_rdata = 16'h2468;
    #1;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== 16'h2468) begin
      errors++;
      $display("FAIL midrst_fresh_resp got dresp=%0b drdata=%h want 1 2468", d_resp, d_rdata);
    end
    step();
    mem_resp = 1'b0;
    d_read = 1'b0;
    step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_i_fetch();
    test_d_write();
    test_rw_both();
    test_contention();
    test_second_contention();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
